// File: rtl/axis_arb_mux_4.sv
// Four-input AXI4-Stream mux with packet-granular round-robin arbitration.
// The grant is held until the owner's tlast beat transfers, and the output beat is registered.
module axis_arb_mux_4 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] input_0_axis_tdata,
    input  logic                  input_0_axis_tvalid,
    output logic                  input_0_axis_tready,
    input  logic                  input_0_axis_tlast,
    input  logic                  input_0_axis_tuser,

    input  logic [DATA_WIDTH-1:0] input_1_axis_tdata,
    input  logic                  input_1_axis_tvalid,
    output logic                  input_1_axis_tready,
    input  logic                  input_1_axis_tlast,
    input  logic                  input_1_axis_tuser,

    input  logic [DATA_WIDTH-1:0] input_2_axis_tdata,
    input  logic                  input_2_axis_tvalid,
    output logic                  input_2_axis_tready,
    input  logic                  input_2_axis_tlast,
    input  logic                  input_2_axis_tuser,

    input  logic [DATA_WIDTH-1:0] input_3_axis_tdata,
    input  logic                  input_3_axis_tvalid,
    output logic                  input_3_axis_tready,
    input  logic                  input_3_axis_tlast,
    input  logic                  input_3_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,

    output logic                  grant_valid,
    output logic [1:0]            grant_encoded
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              grant_encoded_q, grant_encoded_d;
    logic [1:0]              last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   out_tdata_q, out_tdata_d;
    logic                    out_tvalid_q, out_tvalid_d;
    logic                    out_tlast_q, out_tlast_d;
    logic                    out_tuser_q, out_tuser_d;

    logic [3:0]              in_tvalid;
    logic [3:0]              in_tlast;
    logic [3:0]              in_tuser;
    logic [3:0]              in_tready;
    logic [DATA_WIDTH-1:0]   in_tdata [4];

    logic                    sel_ready;
    logic                    xfer;
    logic                    found;
    logic [1:0]              next_port;
    logic [1:0]              cand;

    assign in_tvalid = {input_3_axis_tvalid, input_2_axis_tvalid,
                        input_1_axis_tvalid, input_0_axis_tvalid};
    assign in_tlast  = {input_3_axis_tlast, input_2_axis_tlast,
                        input_1_axis_tlast, input_0_axis_tlast};
    assign in_tuser  = {input_3_axis_tuser, input_2_axis_tuser,
                        input_1_axis_tuser, input_0_axis_tuser};
    assign in_tdata[0] = input_0_axis_tdata;
    assign in_tdata[1] = input_1_axis_tdata;
    assign in_tdata[2] = input_2_axis_tdata;
    assign in_tdata[3] = input_3_axis_tdata;

    // Search starts one past the previous owner; offset 4 wraps back to the previous owner itself.
    always_comb begin
        found     = 1'b0;
        next_port = last_grant_q;
        cand      = last_grant_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant_q + 2'(i);
            if (!found && in_tvalid[cand]) begin
                found     = 1'b1;
                next_port = cand;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_encoded_d = grant_encoded_q;
        last_grant_d    = last_grant_q;
        out_tdata_d     = out_tdata_q;
        out_tvalid_d    = out_tvalid_q;
        out_tlast_d     = out_tlast_q;
        out_tuser_d     = out_tuser_q;
        in_tready       = 4'b0000;

        // Ready depends only on registered state and downstream ready, never on an input tvalid.
        sel_ready = (state_q == ACTIVE) && (output_axis_tready || !out_tvalid_q);
        xfer      = sel_ready && in_tvalid[grant_encoded_q];
        if (sel_ready) begin
            in_tready[grant_encoded_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_encoded_d = next_port;
                    state_d         = ACTIVE;
                end
            end
            ACTIVE: begin
                if (xfer && in_tlast[grant_encoded_q]) begin
                    last_grant_d = grant_encoded_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            out_tdata_d  = in_tdata[grant_encoded_q];
            out_tlast_d  = in_tlast[grant_encoded_q];
            out_tuser_d  = in_tuser[grant_encoded_q];
            out_tvalid_d = 1'b1;
        end else if (output_axis_tready) begin
            out_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_encoded_q <= 2'd0;
            last_grant_q    <= 2'd3;
            out_tdata_q     <= '0;
            out_tvalid_q    <= 1'b0;
            out_tlast_q     <= 1'b0;
            out_tuser_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_encoded_q <= grant_encoded_d;
            last_grant_q    <= last_grant_d;
            out_tdata_q     <= out_tdata_d;
            out_tvalid_q    <= out_tvalid_d;
            out_tlast_q     <= out_tlast_d;
            out_tuser_q     <= out_tuser_d;
        end
    end

    assign input_0_axis_tready = in_tready[0];
    assign input_1_axis_tready = in_tready[1];
    assign input_2_axis_tready = in_tready[2];
    assign input_3_axis_tready = in_tready[3];

    assign output_axis_tdata  = out_tdata_q;
    assign output_axis_tvalid = out_tvalid_q;
    assign output_axis_tlast  = out_tlast_q;
    assign output_axis_tuser  = out_tuser_q;

    assign grant_valid   = (state_q == ACTIVE);
    assign grant_encoded = grant_encoded_q;

endmodule

// File: tb/tb_axis_arb_mux_4.sv
// Self-checking bench for axis_arb_mux_4: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model built from source packet queues.
module tb_axis_arb_mux_4;

    localparam int DW = 8;
    typedef logic [DW+1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data [4];
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [3:0]    in_last;
    logic [3:0]    in_user;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          out_user;
    logic          grant_valid;
    logic [1:0]    grant_encoded;

    always #5 clk = ~clk;

    axis_arb_mux_4 #(.DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_0_axis_tdata  (in_data[0]),
        .input_0_axis_tvalid (in_valid[0]),
        .input_0_axis_tready (in_ready[0]),
        .input_0_axis_tlast  (in_last[0]),
        .input_0_axis_tuser  (in_user[0]),
        .input_1_axis_tdata  (in_data[1]),
        .input_1_axis_tvalid (in_valid[1]),
        .input_1_axis_tready (in_ready[1]),
        .input_1_axis_tlast  (in_last[1]),
        .input_1_axis_tuser  (in_user[1]),
        .input_2_axis_tdata  (in_data[2]),
        .input_2_axis_tvalid (in_valid[2]),
        .input_2_axis_tready (in_ready[2]),
        .input_2_axis_tlast  (in_last[2]),
        .input_2_axis_tuser  (in_user[2]),
        .input_3_axis_tdata  (in_data[3]),
        .input_3_axis_tvalid (in_valid[3]),
        .input_3_axis_tready (in_ready[3]),
        .input_3_axis_tlast  (in_last[3]),
        .input_3_axis_tuser  (in_user[3]),
        .output_axis_tdata   (out_data),
        .output_axis_tvalid  (out_valid),
        .output_axis_tready  (out_ready),
        .output_axis_tlast   (out_last),
        .output_axis_tuser   (out_user),
        .grant_valid         (grant_valid),
        .grant_encoded       (grant_encoded)
    );

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;

    beat_t srcq [4][$];
    beat_t dut_out [$];
    int    out_cyc [$];
    int    dut_grants [$];
    bit    prev_gv;

    bit    m_gv;
    int    m_ge;
    int    m_last;
    bit    m_ov;
    beat_t m_beat;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_gv   = 1'b0;
        m_ge   = 0;
        m_last = 3;
        m_ov   = 1'b0;
        m_beat = '0;
    endtask

    task automatic pushPacket(input int port, input int len, input logic [7:0] base, input bit user_last);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i);
            srcq[port].push_back({(i == len - 1), (user_last && (i == len - 1)), d});
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare, then advance the model.
    task automatic applyStimulus(input bit rst_in, input int valid_pct, input int ready_pct);
        beat_t b;
        bit    rdy;
        bit    xf;
        bit    found;
        int    p;
        rst = rst_in;
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                in_valid[i] = 1'b1;
                b = srcq[i][0];
            end else begin
                in_valid[i] = 1'b0;
                b = beat_t'($urandom);
            end
            in_data[i] = b[DW-1:0];
            in_user[i] = b[DW];
            in_last[i] = b[DW+1];
        end
        out_ready = ($urandom_range(99) < ready_pct);
        #1;

        checkOutput("grant_valid", 32'(grant_valid), 32'(m_gv));
        if (m_gv) checkOutput("grant_encoded", 32'(grant_encoded), 32'(m_ge));
        checkOutput("out_tvalid", 32'(out_valid), 32'(m_ov));
        if (m_ov) checkOutput("out_beat", 32'({out_last, out_user, out_data}), 32'(m_beat));
        rdy = m_gv && (out_ready || !m_ov);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("tready%0d", i), 32'(in_ready[i]), 32'(rdy && (m_ge == i)));
        end

        if (out_valid && out_ready) begin
            dut_out.push_back({out_last, out_user, out_data});
            out_cyc.push_back(cyc);
        end
        if (grant_valid && !prev_gv) dut_grants.push_back(int'(grant_encoded));
        prev_gv = grant_valid;

        if (rst_in) begin
            modelReset();
        end else if (m_gv) begin
            xf = rdy && in_valid[m_ge];
            if (xf) begin
                m_beat = srcq[m_ge].pop_front();
                m_ov   = 1'b1;
                if (m_beat[DW+1]) begin
                    m_last = m_ge;
                    m_gv   = 1'b0;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end else begin
            if (out_ready) m_ov = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                p = (m_last + k) % 4;
                if (!found && in_valid[p]) begin
                    found = 1'b1;
                    m_gv  = 1'b1;
                    m_ge  = p;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic doReset();
        for (int i = 0; i < 4; i++) srcq[i].delete();
        applyStimulus(1'b1, 0, 100);
        dut_out.delete();
        out_cyc.delete();
        dut_grants.delete();
        prev_gv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_user   = '0;
        out_ready = 1'b0;
        prev_gv   = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = '0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Single packet on port 2
        doReset();
        checkOutput("t1_reset_last_grant_free", 32'(grant_valid), 32'd0);
        pushPacket(2, 3, 8'hA1, 1'b0);
        applyStimulus(1'b0, 100, 100);
        checkOutput("t1_gv", 32'(grant_valid), 32'd1);
        checkOutput("t1_ge", 32'(grant_encoded), 32'd2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 100, 100);
        checkOutput("t1_count", 32'(dut_out.size()), 32'd3);
        for (int i = 0; i < 3 && i < dut_out.size(); i++) begin
            checkOutput("t1_beat", 32'(dut_out[i]), 32'({(i == 2), 1'b0, 8'(8'hA1 + i)}));
            if (i > 0) checkOutput("t1_consec", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
        end

        // Simultaneous start on all ports
        doReset();
        for (int p = 0; p < 4; p++) pushPacket(p, 2, 8'(p * 16), 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 100, 100);
        checkOutput("t2_count", 32'(dut_out.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_out.size(); i++) begin
            checkOutput("t2_port", 32'(dut_out[i][7:4]), 32'(i / 2));
            if (i > 0) checkOutput("t2_gap", 32'(out_cyc[i] - out_cyc[i-1]), (i % 2 == 0) ? 32'd2 : 32'd1);
        end

        // Fairness between two saturating ports
        doReset();
        for (int i = 0; i < 40; i++) begin
            if (srcq[0].size() == 0) pushPacket(0, 1, 8'h00, 1'b0);
            if (srcq[1].size() == 0) pushPacket(1, 1, 8'h10, 1'b0);
            applyStimulus(1'b0, 100, 100);
        end
        checkOutput("t3_ngrants", 32'(dut_grants.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < dut_grants.size(); i++) begin
            checkOutput("t3_alternate", 32'(dut_grants[i]), 32'(i % 2));
        end

        // Backpressure on port 3
        doReset();
        pushPacket(3, 2, 8'h10, 1'b0);
        applyStimulus(1'b0, 100, 100);
        applyStimulus(1'b0, 100, 100);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 100, 0);
            checkOutput("t4_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t4_hold_data", 32'(out_data), 32'h10);
            checkOutput("t4_ready3", 32'(in_ready[3]), 32'd0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 100, 100);
        checkOutput("t4_count", 32'(dut_out.size()), 32'd2);
        if (dut_out.size() == 2) begin
            checkOutput("t4_first", 32'(dut_out[0]), 32'({1'b0, 1'b0, 8'h10}));
            checkOutput("t4_second", 32'(dut_out[1]), 32'({1'b1, 1'b0, 8'h11}));
            checkOutput("t4_next_cycle", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
        end

        // Reset in the middle of a port 1 packet while port 0 waits
        doReset();
        pushPacket(1, 4, 8'h40, 1'b0);
        applyStimulus(1'b0, 100, 100);
        applyStimulus(1'b0, 100, 100);
        pushPacket(0, 2, 8'h50, 1'b0);
        applyStimulus(1'b1, 100, 100);
        srcq[1].delete();
        checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_gv", 32'(grant_valid), 32'd0);
        checkOutput("t5_treadys", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 100, 100);
        checkOutput("t5_regrant_gv", 32'(grant_valid), 32'd1);
        checkOutput("t5_regrant_port0", 32'(grant_encoded), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 100, 100);

        // Isolation of a waiting port and tuser pass-through
        doReset();
        pushPacket(1, 3, 8'h60, 1'b1);
        pushPacket(2, 2, 8'h70, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 100, 100);
            if (grant_valid && grant_encoded == 2'd1) checkOutput("t6_iso_ready2", 32'(in_ready[2]), 32'd0);
        end
        checkOutput("t6_count", 32'(dut_out.size()), 32'd5);
        for (int i = 0; i < 3 && i < dut_out.size(); i++) begin
            checkOutput("t6_p1_beat", 32'(dut_out[i]), 32'({(i == 2), (i == 2), 8'(8'h60 + i)}));
        end

        // Randomized traffic with occasional resets
        doReset();
        for (int i = 0; i < 800; i++) begin
            for (int p = 0; p < 4; p++) begin
                if (srcq[p].size() == 0 && $urandom_range(3) == 0)
                    pushPacket(p, $urandom_range(1, 4), 8'($urandom), 1'($urandom));
            end
            if ($urandom_range(199) == 0) begin
                applyStimulus(1'b1, 70, 70);
                for (int p = 0; p < 4; p++) srcq[p].delete();
            end else begin
                applyStimulus(1'b0, 70, 70);
            end
        end
        for (int i = 0; i < 300 && (srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()) > 0; i++)
            applyStimulus(1'b0, 100, 100);
        for (int p = 0; p < 4; p++) checkOutput($sformatf("drain%0d", p), 32'(srcq[p].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
